// File: rtl/ib_flit_reader.sv
// Read-side controller for the router input buffer: frames packets by flit type,
// requests a route per head flit and streams the packet out. Macro IB_FLIT_READER_DROPCNT_EN enables the drop counter.
module ib_flit_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 5,
    parameter int DEST_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DEPTH-1:0]      valid_flit_i,
    output logic [ADDR_WIDTH-1:0] ram_raddr_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic [DEPTH-1:0]      flit_pop_o,
    output logic                  route_req_o,
    output logic [DEST_WIDTH-1:0] route_dest_o,
    input  logic                  route_grant_i,
    output logic                  flit_valid_o,
    output logic [DATA_WIDTH-1:0] flit_data_o,
    input  logic                  flit_ready_i,
    output logic [7:0]            drop_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] next_ptr;
    logic [DEPTH-1:0]      ptr_onehot;
    logic [1:0]            flit_type;
    logic                  slot_ready;
    logic                  is_head;
    logic                  is_last;
    logic                  load;

`ifdef IB_FLIT_READER_DROPCNT_EN
    logic [7:0] drop_count;
    assign drop_count_o = drop_count;
`else
    assign drop_count_o = 8'd0;
`endif

    always_comb begin
        ptr_onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ptr_onehot[i] = (rd_ptr == ADDR_WIDTH'(i));
        end
    end

    // Head (01) and single (11) share bit 0; tail (10) and single share bit 1.
    assign flit_type   = ram_rdata_i[DATA_WIDTH-1 -: 2];
    assign is_head     = flit_type[0];
    assign is_last     = flit_type[1];
    assign slot_ready  = |(valid_flit_i & ptr_onehot);
    assign next_ptr    = (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign load        = (state == XFER) && slot_ready && (!flit_valid_o || flit_ready_i);
    assign ram_raddr_o = rd_ptr;
    assign route_req_o = (state == REQ) || (state == XFER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            flit_pop_o   <= '0;
            route_dest_o <= '0;
            flit_valid_o <= 1'b0;
            flit_data_o  <= '0;
`ifdef IB_FLIT_READER_DROPCNT_EN
            drop_count   <= 8'd0;
`endif
        end else begin
            flit_pop_o <= '0;
            // An accepted flit leaves the register unless a new one loads below.
            if (flit_valid_o && flit_ready_i) begin
                flit_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (slot_ready) begin
                        if (is_head) begin
                            route_dest_o <= ram_rdata_i[DEST_WIDTH-1:0];
                            state        <= REQ;
                        end else begin
                            flit_pop_o <= ptr_onehot;
                            rd_ptr     <= next_ptr;
`ifdef IB_FLIT_READER_DROPCNT_EN
                            if (drop_count != 8'hFF) begin
                                drop_count <= drop_count + 8'd1;
                            end
`endif
                        end
                    end
                end
                REQ: begin
                    if (route_grant_i) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (load) begin
                        flit_data_o  <= ram_rdata_i;
                        flit_valid_o <= 1'b1;
                        flit_pop_o   <= ptr_onehot;
                        rd_ptr       <= next_ptr;
                        if (is_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ib_flit_reader.md
Name: ib_flit_reader

Overview:
- Read-side controller for the router input buffer.
- Walks the buffer's slots in circular order and presents each slot's read address.
- Uses per-slot valid bits to detect occupancy, and frames packets by flit type.
- Requests a route for each head flit, then streams the packet to the crossbar over a valid/ready handshake, popping (invalidating) each slot as its flit is taken.

Parameters:
DATA_WIDTH, 16, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] are the flit type
ADDR_WIDTH, 3, buffer address width
DEPTH, 5, number of buffer slots (need not be a power of 2)
DEST_WIDTH, 4, destination field width, head flit bits [DEST_WIDTH-1:0]

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
valid_flit_i  input  DEPTH  per-slot occupied flags from buffer
ram_raddr_o  output  ADDR_WIDTH  read address (= read pointer)
ram_rdata_i  input  DATA_WIDTH  flit at ram_raddr_o (combinational read)
flit_pop_o  output  DEPTH  one-hot, 1-cycle pulse: clear slot valid
route_req_o  output  1  switch/route request, held for whole packet
route_dest_o  output  DEST_WIDTH  destination of current packet
route_grant_i  input  1  grant for route_req_o
flit_valid_o  output  1  output flit valid (registered)
flit_data_o  output  DATA_WIDTH  output flit (registered)
flit_ready_i  input  1  downstream accepts flit when valid & ready
drop_count_o  output  8  malformed-flit drop count (see Optional Feature)

Behaviour:
- Flit types: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single-flit packet (head+tail).
- Reset (reset=0, async): rd_ptr=0, state IDLE, flit_valid_o=0, flit_data_o=0, route_req_o=0, route_dest_o=0, flit_pop_o=0, drop_count_o=0.
- ram_raddr_o = rd_ptr at all times.
- "Slot ready" = valid_flit_i[rd_ptr].
- rd_ptr advance: DEPTH-1 wraps to 0. Pointer advances only on a pop, and at most one pop per cycle.
- FSM states: IDLE, REQ, XFER.
- IDLE, slot ready, type head or single:
  - latch route_dest_o = ram_rdata_i[DEST_WIDTH-1:0]
  - next state REQ; no pop.
- IDLE, slot ready, type body or tail (malformed):
  - pop slot (flit_pop_o[rd_ptr]=1), advance rd_ptr, stay IDLE.
- REQ: route_req_o=1. On route_grant_i=1, next state XFER; otherwise hold indefinitely.
- XFER: route_req_o=1. Load condition: slot ready AND (flit_valid_o=0 OR flit_ready_i=1). When it holds:
  - flit_data_o <= ram_rdata_i and flit_valid_o <= 1
  - pop the slot and advance rd_ptr
  - if the loaded flit type is tail or single, next state IDLE.
- Output register: a flit accepted (valid & ready) with no load the same cycle clears flit_valid_o. Load while valid & ready gives a back-to-back flit (1 flit/cycle sustained).
- route_req_o is a decode of state (REQ or XFER), so it drops in the cycle after the tail is loaded. The tail may still be pending in the output register.
- IDLE may detect the next head while the previous tail is still in the output register. The next packet's XFER load is gated by the output-register rule above.
- Latency, head in slot with grant tied high:
  - cycle 0: IDLE detects head
  - cycle 1: REQ
  - cycle 2: XFER pops head
  - cycle 3: flit_valid_o=1
- XFER with slot empty: wait, no pop, keep route_req_o.
- Empty buffer: nothing happens; outputs hold.
- Reset mid-packet: in-flight flit discarded, flit_valid_o drops immediately; buffer contents are the writer's responsibility.

Optional Feature:
- Macro IB_FLIT_READER_DROPCNT_EN.
- Defined: drop_count_o increments on each malformed-flit pop in IDLE, saturating at 255. Cleared only by reset.
- Undefined: drop_count_o tied to 0 and no counter flops; drop behaviour is unchanged.

Test Plan:
- Reset, then slots 0..2 = head(dest=4'h3), body 16'h0AAA, tail 16'h8BBB; grant high, ready high:
  - route_dest_o=3, route_req_o high cycles 1-4
  - flit_data_o = 16'h4003, 16'h0AAA, 16'h8BBB on cycles 3,4,5
  - flit_pop_o = 5'b00001, 5'b00010, 5'b00100.
- Wrap: rd_ptr=3, packet head/body/tail in slots 3,4,0 -> ram_raddr_o sequence 3,4,0, pops in the same order, ends with rd_ptr=1.
- Backpressure: flit_ready_i low for 4 cycles mid-packet -> flit_data_o stable, no pops during stall, no flit lost or duplicated after ready rises.
- Grant delay: route_grant_i low 6 cycles -> route_req_o held, no pops, flit_valid_o=0 until 2 cycles after grant.
- Malformed: body flit at slot 0 in IDLE -> popped, no route_req_o; with macro, drop_count_o=1. Preloaded 300 drops -> 255.
- Single-flit packets 16'hC001 and 16'hC002 back-to-back, ready high -> two flits on consecutive-load cycles, route_req_o deasserts between packets; async reset mid-XFER -> flit_valid_o=0 immediately, rd_ptr=0.
